calculator_core_seq: RTL

//  Parametrised successor of the hex calculator datapath: W-bit operands, RES_W-bit result.

---
 rtl/calc_pkg.sv | 25 ++
 rtl/calculator_seq_muldiv.sv | 93 +++++++++
 rtl/calculator_core_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the sequential calculator core: function codes, FSM states
// and the dispatch rule deciding which operations need the iterative datapath.
package calc_pkg;

  typedef logic [2:0] func_t;

  localparam func_t FUNC_ADD = 3'b000;
  localparam func_t FUNC_SUB = 3'b001;
  localparam func_t FUNC_MUL = 3'b010;
  localparam func_t FUNC_DIV = 3'b011;
  localparam func_t FUNC_AND = 3'b100;
  localparam func_t FUNC_OR  = 3'b101;
  localparam func_t FUNC_XOR = 3'b110;
  localparam func_t FUNC_ACC = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A zero divisor is resolved immediately, so it never enters the iterative path.
  function automatic logic is_iterative(input func_t f, input logic divisor_zero);
    return (f == FUNC_MUL) || ((f == FUNC_DIV) && !divisor_zero);
  endfunction

endpackage

// File: rtl/calculator_seq_muldiv.sv
// Iterative W-step datapath: LSB-first shift-add multiply and restoring divide.
// Outputs carry the final-step values combinationally while valid is high.
module calculator_seq_muldiv
  import calc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk_g,
  input  logic           rst_n,
  input  logic           start,
  input  logic           op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           valid,
  output logic [2*W-1:0] prod,
  output logic [W-1:0]   quot,
  output logic [W-1:0]   rem
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  logic           r_run;
  logic           r_op;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_prod;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [W-1:0]   r_quo;
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_div;

  logic [2*W-1:0] w_prod_next;
  logic [W:0]     w_shift;
  logic [W:0]     w_trial;
  logic           w_qbit;
  logic [W-1:0]   w_rem_next;
  logic [W-1:0]   w_quo_next;
  logic           w_last;

  assign w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

  // Partial remainder stays below the divisor, so W+1 bits hold the trial subtraction.
  assign w_shift    = {r_rem, r_quo[W-1]};
  assign w_trial    = w_shift - {1'b0, r_div};
  assign w_qbit     = ~w_trial[W];
  assign w_rem_next = w_qbit ? w_trial[W-1:0] : w_shift[W-1:0];
  assign w_quo_next = {r_quo[W-2:0], w_qbit};

  assign w_last = r_run && (r_cnt == CNT_LAST);
  assign valid  = w_last;
  assign prod   = w_prod_next;
  assign quot   = w_quo_next;
  assign rem    = w_rem_next;

  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_op     <= 1'b0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
    end else if (start) begin
      r_run    <= 1'b1;
      r_op     <= op;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= {{W{1'b0}}, a};
      r_mplier <= b;
      r_quo    <= a;
      r_rem    <= '0;
      r_div    <= b;
    end else if (r_run) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_run <= 1'b0;
      end
      if (!r_op) begin
        r_prod   <= w_prod_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end else begin
        r_quo <= w_quo_next;
        r_rem <= w_rem_next;
      end
    end
  end

endmodule

// File: rtl/calculator_core_seq.sv
// Sequential calculator core: button-edge start, single-cycle ALU ops, accumulator,
// and an iterative multiply/divide unit, with busy/done status toward the display.
//
//  state   | meaning
//  IDLE    | waiting for a rising button edge; only state that accepts a start
//  CALC    | mul/div iterating, busy high, cal_result held
//  DONE    | result/error just written, done high for this one cycle
module calculator_core_seq
  import calc_pkg::*;
#(
  parameter int W     = 8,
  parameter int RES_W = 32
) (
  input  logic             clk_g,
  input  logic             rst_n,
  input  logic             button,
  input  logic [2:0]       func,
  input  logic [W-1:0]     num1,
  input  logic [W-1:0]     num2,
  output logic [RES_W-1:0] cal_result,
  output logic             error,
  output logic             busy,
  output logic             done
);

  logic [1:0]       r_state;
  logic             r_button_q;
  logic [2:0]       r_func;
  logic [RES_W-1:0] r_acc;

  logic             w_start;
  logic             w_iter;
  logic [W:0]       w_add_sum;
  logic [RES_W:0]   w_acc_sum;
  logic [RES_W-1:0] w_sc_result;
  logic             w_sc_error;
  logic             w_md_valid;
  logic [2*W-1:0]   w_md_prod;
  logic [W-1:0]     w_md_quot;
  logic [W-1:0]     w_md_rem;
  logic [RES_W-1:0] w_md_result;

  assign w_start = button && !r_button_q && (r_state == ST_IDLE);
  assign w_iter  = is_iterative(func, num2 == '0);

  calculator_seq_muldiv #(.W(W)) u_muldiv (
    .clk_g (clk_g),
    .rst_n (rst_n),
    .start (w_start && w_iter),
    .op    (func == FUNC_DIV),
    .a     (num1),
    .b     (num2),
    .valid (w_md_valid),
    .prod  (w_md_prod),
    .quot  (w_md_quot),
    .rem   (w_md_rem)
  );

  assign w_add_sum   = {1'b0, num1} + {1'b0, num2};
  assign w_acc_sum   = {1'b0, r_acc} + {{(RES_W + 1 - W){1'b0}}, num1};
  assign w_md_result = (r_func == FUNC_DIV) ? RES_W'({w_md_quot, w_md_rem})
                                            : RES_W'(w_md_prod);

  always_comb begin
    w_sc_result = '0;
    w_sc_error  = 1'b0;
    case (func)
      FUNC_ADD: w_sc_result = RES_W'(w_add_sum);
      FUNC_SUB: w_sc_result = RES_W'(num1) - RES_W'(num2);
      FUNC_AND: w_sc_result = RES_W'(num1 & num2);
      FUNC_OR:  w_sc_result = RES_W'(num1 | num2);
      FUNC_XOR: w_sc_result = RES_W'(num1 ^ num2);
      FUNC_ACC: begin
        w_sc_result = w_acc_sum[RES_W-1:0];
        w_sc_error  = w_acc_sum[RES_W];
      end
      // Only reached with a zero divisor; a real divide goes through CALC.
      FUNC_DIV: w_sc_error = 1'b1;
      default:  w_sc_result = '0;
    endcase
  end

  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_button_q <= 1'b0;
      r_func     <= FUNC_ADD;
      r_acc      <= '0;
      cal_result <= '0;
      error      <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_button_q <= button;
      done       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_func <= func;
            if (w_iter) begin
              r_state <= ST_CALC;
            end else begin
              cal_result <= w_sc_result;
              error      <= w_sc_error;
              done       <= 1'b1;
              r_state    <= ST_DONE;
              if (func == FUNC_ACC) begin
                r_acc <= w_acc_sum[RES_W-1:0];
              end
            end
          end
        end
        ST_CALC: begin
          if (w_md_valid) begin
            cal_result <= w_md_result;
            error      <= 1'b0;
            done       <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_CALC);

endmodule
